keypad_scan: RTL and testbench
==============================

# keypad_scan

Matrix-keypad front end for the two-function calculator. It scans a 4x4 active-low keypad, debounces the row returns, and converts the pressed key to a 4-bit code. It delivers that code with a one-cycle `trig` strobe to the digit-entry/input stage, which feeds operand A to the control unit and the arithmetic unit. It replaces free-running scan logic with a deterministic, testable scanner FSM.

## Interface
Parameters:
- `SCAN_DIV`, 50000: clock cycles per scan tick; minimum 2.
- `DEBOUNCE_N`, 4: consecutive matching ticks required to accept a press or a release; minimum 1.
- `REPEAT_DLY`, 100: ticks a key must be held before auto-repeat starts. Used only with the macro.
- `REPEAT_PER`, 25: ticks between repeat strobes. Used only with the macro.

Ports:
- `clock`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `row`, in, 4: keypad row returns, active-low, asynchronous to `clock`.
- `col`, out, 4: column drive, active-low, one-hot-zero.
- `value`, out, 4: code of the last accepted key.
- `valid`, out, 1: high while the debounced key is held.
- `trig`, out, 1: one-cycle strobe per accepted press.

## Operation
- `row` passes through a 2-flop synchronizer. All decisions use the synchronized copy, `row_s`.
- A tick counter counts 0..`SCAN_DIV`-1. `tick` is high for one cycle when the count equals `SCAN_DIV`-1, and the counter then wraps to 0.
- Key map, row r and column c (both 0-based):
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: *, 0, #, D
  - Codes: digits map to 0x0..0x9, A..D map to 0xA..0xD, `*` = 0xE, `#` = 0xF.
- FSM states: SCAN, PRESS_DB, HELD, RELEASE_DB.
  - **SCAN:** on each tick, if `row_s` has exactly one low bit, latch (r, c) as the candidate, clear the match counter, and go to PRESS_DB with `col` frozen. Otherwise rotate `col` to the next column (1110 → 1101 → 1011 → 0111 → 1110). Zero or two-plus low bits count as no key.
  - **PRESS_DB:** on each tick, if `row_s` equals the candidate pattern, increment the match counter. When the count reaches `DEBOUNCE_N`, load `value`, pulse `trig`, set `valid`, and go to HELD. Any mismatch returns to SCAN and resumes rotation from the same column.
  - **HELD:** `col` stays frozen. A tick with `row_s` == 1111 clears the counter and goes to RELEASE_DB. Any other pattern (including a second key) is ignored.
  - **RELEASE_DB:** each tick with `row_s` == 1111 increments the counter. At `DEBOUNCE_N`, clear `valid` and go to SCAN. Any low bit returns to HELD with no new `trig`.
- `value` holds its last code after release, until the next accepted press.
- Reset values: `col` = 1110, `value` = 0, `valid` = 0, `trig` = 0, state = SCAN, all counters and synchronizer flops cleared. Reset may arrive mid-press; after reset release, a still-held key is re-detected and produces a new `trig`.

## Timing
- Decisions are taken only in the cycle where `tick` is high. State and outputs update on the following clock edge.
- Press latency, measured from the first tick that sees the key in SCAN: `trig` rises on the edge after tick number `DEBOUNCE_N` of PRESS_DB, i.e. `DEBOUNCE_N` ticks plus 1 cycle. Add 2 cycles of synchronizer delay from the `row` pin.
- `trig` is exactly 1 cycle wide. `valid` rises on the same edge as `trig`.
- `col` changes only on tick edges, so a column is stable for `SCAN_DIV` cycles before its row is sampled.

## Configuration
- `KEYPAD_REPEAT_EN` defined:
  - In HELD, a repeat counter counts ticks.
  - After `REPEAT_DLY` ticks, `trig` pulses once with `value` unchanged.
  - Further pulses follow every `REPEAT_PER` ticks.
  - The counter clears on entry to HELD and is not reset by a RELEASE_DB → HELD bounce.
- `KEYPAD_REPEAT_EN` undefined: no repeat logic or counters exist, and exactly one `trig` is produced per press.

## Structure
- Shared package `calc_pkg` contains:
  - The key-code constants (`KEY_STAR` = 4'hE, `KEY_HASH` = 4'hF, `KEY_A`..`KEY_D`).
  - The scanner state enum.
  - The 4x4 code lookup function.
- Sub-module `scan_tick`: parameterized divider producing `tick`, with `clock`/`reset` ports. It is reused by any future display multiplexer.
- The synchronizer, FSM, debounce/repeat counters, and output registers live in `keypad_scan`.

## Test plan
All scenarios use `SCAN_DIV`=4 and `DEBOUNCE_N`=3.
- **Reset and idle rotation:** assert and deassert reset with all rows high → `col` = 1110 after reset, then steps through 1101, 1011, 0111, 1110 every 4 cycles; `trig` and `valid` stay 0.
- **Clean press/release:** hold the key at row1/col2 ("6") → `trig` pulses exactly once with `value` = 0x6 and `valid` = 1, and `col` freezes at 1011. Release → `valid` falls after 3 all-high ticks; `value` stays 0x6.
- **Bounce rejection:** on row3/col0 ("*"), toggle the row low for 1 tick, then high → no `trig` and rotation resumes. A stable press then yields `value` = 0xE.
- **Release bounce:** while "0" is held, go high for 2 ticks, then low again → `valid` stays 1 and no second `trig`.
- **Multi-key/ghost:** pull rows 0 and 2 low together in SCAN → ignored, no `trig`. Reset mid-PRESS_DB → all outputs return to reset values, and the held key later yields a fresh `trig`.
- **Repeat (with `KEYPAD_REPEAT_EN`, `REPEAT_DLY`=5, `REPEAT_PER`=2):** hold "#" → initial `trig`, then `trig` again 5 ticks later and every 2 ticks after; `value` = 0xF throughout.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator definitions: key codes, keypad scanner state encoding,
// and helpers that map active-low row/column patterns to key codes.
package calc_pkg;

  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  localparam logic [3:0] ROW_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    ST_SCAN       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_HELD       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } scan_state_e;

  // True when exactly one bit of an active-low pattern is low.
  function automatic logic one_low(input logic [3:0] p);
    case (p)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] p);
    case (p)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    if (c == 2'd3) begin
      code = KEY_A + {2'b00, r};
    end else if (r == 2'd3) begin
      case (c)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'h0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/scan_tick.sv
// Free-running divider: tick is high for one cycle every DIV clocks.
module scan_tick #(
  parameter int DIV = 50000
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner with debounce and key-code output.
// Optional auto-repeat is built when KEYPAD_REPEAT_EN is defined.
module keypad_scan
  import calc_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int DEBOUNCE_N = 4
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int REPEAT_DLY = 100,
  parameter int REPEAT_PER = 25
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [3:0]  value,
  output logic        valid,
  output logic        trig,
  output scan_state_e dbg_state
);

  // valid is a level, high while the debounced key is held; trig is a
  // one-cycle strobe per accepted key. There is no ready: the consumer
  // must take value in the cycle trig is high.

  localparam int CW = $clog2(DEBOUNCE_N + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_N - 1);

  logic          tick;
  logic [3:0]    row_m, row_s, cand;
  logic [CW-1:0] cnt;
  scan_state_e   state, next_state;
  logic          ld_cand, cnt_clr, cnt_inc, rotate, accept, rel_done, rpt_fire;
`ifdef KEYPAD_REPEAT_EN
  logic          rpt_tick;
`endif

  scan_tick #(.DIV(SCAN_DIV)) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_m <= '0;
      row_s <= '0;
    end else begin
      row_m <= row;
      row_s <= row_m;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_SCAN;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (tick) begin
      case (state)
        ST_SCAN:       if (one_low(row_s)) next_state = ST_PRESS_DB;
        ST_PRESS_DB:   if (row_s != cand) next_state = ST_SCAN;
                       else if (cnt == DB_LAST) next_state = ST_HELD;
        ST_HELD:       if (row_s == ROW_IDLE) next_state = ST_RELEASE_DB;
        ST_RELEASE_DB: if (row_s != ROW_IDLE) next_state = ST_HELD;
                       else if (cnt == DB_LAST) next_state = ST_SCAN;
        default:       next_state = ST_SCAN;
      endcase
    end
  end

  always_comb begin
    ld_cand  = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    rotate   = 1'b0;
    accept   = 1'b0;
    rel_done = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rpt_tick = 1'b0;
`endif
    if (tick) begin
      case (state)
        ST_SCAN: begin
          if (one_low(row_s)) begin
            ld_cand = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            rotate = 1'b1;
          end
        end
        ST_PRESS_DB: begin
          if (row_s == cand) begin
            if (cnt == DB_LAST) accept  = 1'b1;
            else                cnt_inc = 1'b1;
          end
        end
        ST_HELD: begin
          if (row_s == ROW_IDLE) cnt_clr = 1'b1;
`ifdef KEYPAD_REPEAT_EN
          else rpt_tick = 1'b1;
`endif
        end
        ST_RELEASE_DB: begin
          if (row_s == ROW_IDLE) begin
            if (cnt == DB_LAST) rel_done = 1'b1;
            else                cnt_inc  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DLY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PER - 1);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_phase;

  assign rpt_fire = rpt_tick && (rpt_cnt == (rpt_phase ? PER_LAST : DLY_LAST));

  // Cleared only on a fresh press, so a release bounce keeps the repeat cadence.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
    end else if (accept) begin
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
    end else if (rpt_fire) begin
      rpt_cnt   <= '0;
      rpt_phase <= 1'b1;
    end else if (rpt_tick) begin
      rpt_cnt   <= rpt_cnt + RW'(1);
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col   <= 4'b1110;
      cand  <= '0;
      cnt   <= '0;
      value <= '0;
      valid <= 1'b0;
      trig  <= 1'b0;
    end else begin
      trig <= accept | rpt_fire;
      if (rotate)  col  <= {col[2:0], col[3]};
      if (ld_cand) cand <= row_s;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + CW'(1);
      // col is still frozen on the candidate column when the press is accepted.
      if (accept) begin
        value <= key_code(low_index(cand), low_index(col));
        valid <= 1'b1;
      end
      if (rel_done) valid <= 1'b0;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan with a behavioural 4x4 keypad matrix.
// Build with KEYPAD_REPEAT_EN defined to also exercise auto-repeat.
module tb_keypad_scan;
  import calc_pkg::*;

  localparam int SCAN_DIV   = 4;
  localparam int DEBOUNCE_N = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  row, col, value;
  logic        valid, trig;
  scan_state_e dbg_state;
  logic [15:0] keys;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0] r;
    logic [1:0] c;
    logic [3:0] code;
  } vec_t;
  vec_t vecs[8];

  keypad_scan #(
    .SCAN_DIV   (SCAN_DIV),
    .DEBOUNCE_N (DEBOUNCE_N)
`ifdef KEYPAD_REPEAT_EN
    ,
    .REPEAT_DLY (5),
    .REPEAT_PER (2)
`endif
  ) u_dut (
    .clock     (clock),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .value     (value),
    .valid     (valid),
    .trig      (trig),
    .dbg_state (dbg_state)
  );

  always #5 clock = ~clock;

  // A pressed key at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] key_bit(input logic [1:0] r, input logic [1:0] c);
    logic [15:0] one = 16'd1;
    return one << ({2'b00, r} * 4 + {2'b00, c});
  endfunction

  function automatic logic [3:0] col_pat(input logic [1:0] c);
    logic [3:0] one = 4'b0001;
    return ~(one << c);
  endfunction

  task automatic wait_trig(input string name, input logic [3:0] exp_code, input logic [3:0] exp_col);
    bit seen = 1'b0;
    for (int i = 0; i < 120 && !seen; i++) begin
      cyc(1);
      if (trig) seen = 1'b1;
    end
    check({name, " trig seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({name, " value"}, 32'(value), 32'(exp_code));
      check({name, " valid"}, 32'(valid), 32'd1);
      check({name, " col frozen"}, 32'(col), 32'(exp_col));
    end
  endtask

  task automatic watch(input int n, output int trigs, output int valid_low, output int col_chg);
    logic [3:0] pc;
    trigs = 0; valid_low = 0; col_chg = 0;
    pc = col;
    for (int i = 0; i < n; i++) begin
      cyc(1);
      trigs     += int'(trig);
      valid_low += int'(!valid);
      if (col != pc) col_chg++;
      pc = col;
    end
  endtask

  task automatic release_key(input string name, input logic [3:0] exp_code);
    bit fell = 1'b0;
    keys = '0;
    for (int i = 0; i < 60 && !fell; i++) begin
      cyc(1);
      if (!valid) fell = 1'b1;
    end
    check({name, " valid fell"}, 32'(fell), 32'd1);
    check({name, " value held"}, 32'(value), 32'(exp_code));
    cyc(2);
  endtask

  task automatic wait_col(input logic [3:0] target);
    bit found = 1'b0;
    logic [3:0] pc;
    for (int i = 0; i < 100 && !found; i++) begin
      pc = col;
      cyc(1);
      if (col == target && pc != target) found = 1'b1;
    end
    check("wait_col", 32'(found), 32'd1);
  endtask

  initial begin
    int first, trigs, vl, cc, t1, t2;
    int offs[3];

    vecs[0] = '{2'd0, 2'd0, 4'h1};
    vecs[1] = '{2'd0, 2'd3, 4'hA};
    vecs[2] = '{2'd1, 2'd0, 4'h4};
    vecs[3] = '{2'd1, 2'd3, 4'hB};
    vecs[4] = '{2'd2, 2'd2, 4'h9};
    vecs[5] = '{2'd2, 2'd3, 4'hC};
    vecs[6] = '{2'd3, 2'd3, 4'hD};
    vecs[7] = '{2'd3, 2'd2, 4'hF};

    // Reset and idle rotation.
    keys  = '0;
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    check("reset col", 32'(col), 32'hE);
    check("reset value", 32'(value), 32'h0);
    check("reset valid", 32'(valid), 32'd0);
    check("reset trig", 32'(trig), 32'd0);
    check("reset state", 32'(dbg_state), 32'(ST_SCAN));
    cyc(3);
    check("col before tick", 32'(col), 32'hE);
    cyc(1);
    check("col step1", 32'(col), 32'hD);
    cyc(4);
    check("col step2", 32'(col), 32'hB);
    cyc(4);
    check("col step3", 32'(col), 32'h7);
    cyc(4);
    check("col wrap", 32'(col), 32'hE);

    // Clean press of "6" with exact latency, then release.
    keys = key_bit(2'd1, 2'd2);
    first = 0; trigs = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc(1);
      if (trig) begin
        trigs++;
        if (first == 0) begin
          first = i;
          check("six value", 32'(value), 32'h6);
          check("six valid", 32'(valid), 32'd1);
        end
      end
    end
    check("six trig cycle", 32'(first), 32'd24);
    check("six trig count", 32'(trigs), 32'd1);
    check("six col frozen", 32'(col), 32'hB);
    keys = '0;
    first = 0;
    for (int i = 1; i <= 30; i++) begin
      cyc(1);
      if (!valid && first == 0) first = i;
    end
    check("six release cycle", 32'(first), 32'd16);
    check("six value held", 32'(value), 32'h6);

    // Bounce rejection on "*": low for one tick only.
    wait_col(4'hE);
    keys = key_bit(2'd3, 2'd0);
    cyc(4);
    check("bounce in press_db", 32'(dbg_state), 32'(ST_PRESS_DB));
    keys = '0;
    watch(4, t1, vl, cc);
    check("bounce col same", 32'(col), 32'hE);
    watch(4, t2, vl, cc);
    check("bounce col resumes", 32'(col), 32'hD);
    check("bounce no trig", 32'(t1 + t2), 32'd0);
    check("bounce valid", 32'(valid), 32'd0);
    keys = key_bit(2'd3, 2'd0);
    wait_trig("star", KEY_STAR, 4'hE);
    watch(16, trigs, vl, cc);
    check("star single trig", 32'(trigs), 32'd0);
    release_key("star", KEY_STAR);

    // Release bounce on "0": two idle ticks then pressed again.
    keys = key_bit(2'd3, 2'd1);
    wait_trig("zero", 4'h0, 4'hD);
    cyc(4);
    keys = '0;
    cyc(8);
    check("relbounce state", 32'(dbg_state), 32'(ST_RELEASE_DB));
    keys = key_bit(2'd3, 2'd1);
    watch(16, trigs, vl, cc);
    check("relbounce no trig", 32'(trigs), 32'd0);
    check("relbounce valid kept", 32'(vl), 32'd0);
    check("relbounce back held", 32'(dbg_state), 32'(ST_HELD));
    release_key("zero", 4'h0);

    // Two keys in one column: ignored, rotation continues.
    keys = key_bit(2'd0, 2'd1) | key_bit(2'd2, 2'd1);
    watch(40, trigs, vl, cc);
    check("ghost no trig", 32'(trigs), 32'd0);
    check("ghost valid low", 32'(vl), 32'd40);
    check("ghost rotation", 32'(cc), 32'd10);
    keys = '0;
    cyc(4);

    // Key map table.
    for (int k = 0; k < 8; k++) begin
      keys = key_bit(vecs[k].r, vecs[k].c);
      wait_trig($sformatf("key%0d", k), vecs[k].code, col_pat(vecs[k].c));
      watch(16, trigs, vl, cc);
      check($sformatf("key%0d single trig", k), 32'(trigs), 32'd0);
      release_key($sformatf("key%0d", k), vecs[k].code);
    end

    // Reset in the middle of PRESS_DB, key kept held.
    wait_col(4'hD);
    keys = key_bit(2'd2, 2'd1);
    cyc(6);
    check("midreset pre state", 32'(dbg_state), 32'(ST_PRESS_DB));
    reset = 1'b1;
    #1;
    check("midreset col", 32'(col), 32'hE);
    check("midreset value", 32'(value), 32'h0);
    check("midreset valid", 32'(valid), 32'd0);
    check("midreset trig", 32'(trig), 32'd0);
    check("midreset state", 32'(dbg_state), 32'(ST_SCAN));
    cyc(2);
    reset = 1'b0;
    wait_trig("eight after reset", 4'h8, 4'hD);
    release_key("eight", 4'h8);

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat on "#": 5 ticks after the first strobe, then every 2 ticks.
    keys = key_bit(2'd3, 2'd2);
    wait_trig("hash", KEY_HASH, 4'hB);
    trigs = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc(1);
      if (trig) begin
        if (trigs < 3) offs[trigs] = i;
        trigs++;
        check("repeat value", 32'(value), 32'(KEY_HASH));
      end
    end
    check("repeat count", 32'(trigs), 32'd3);
    if (trigs >= 3) begin
      check("repeat first", 32'(offs[0]), 32'd20);
      check("repeat second", 32'(offs[1]), 32'd28);
      check("repeat third", 32'(offs[2]), 32'd36);
    end
    release_key("hash", KEY_HASH);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
